onewire_temp_master: RTL and testbench
======================================

ONEWIRE_TEMP_MASTER -- requirements
Module: onewire_temp_master

Interface
REQ-001 Parameter FCLK_MHZ, default 125, clock frequency in MHz, used for the 1 us tick divider.
REQ-002 Parameter CONV_WAIT_MS, default 750, conversion wait after the Convert T command.
REQ-003 Parameter READ_BYTES, default 9, range 2..9, number of scratchpad bytes read.
REQ-004 Parameter PRESENCE_MIN_US, default 60, minimum low time that qualifies as a presence pulse.
REQ-005 clk  in  1  system clock; the block uses this single clock.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle request to begin a measurement.
REQ-008 busy  out  1  high from the cycle after an accepted start until done.
REQ-009 done  out  1  one-cycle pulse marking the end of a measurement, whether it passed or failed.
REQ-010 err_presence  out  1  no valid presence pulse in the last measurement; held until the next start.
REQ-011 err_crc  out  1  scratchpad CRC mismatch in the last measurement; held until the next start.
REQ-012 temp_data  out  16  raw temperature: {byte1, byte0}.
REQ-013 temp_valid  out  1  set after the first successful measurement; held until reset.
REQ-014 dq_oe  out  1  line drive enable; the top level ties the pin to zero when dq_oe is high.
REQ-015 dq_out  out  1  line drive value; this block always drives 0 when dq_oe=1.
REQ-016 dq_in  in  1  line sample; two-flop synchronised inside the block.

Function
REQ-017 A 1 us tick is generated every FCLK_MHZ clocks; every timing below counts in ticks, tolerance ±1 tick.
REQ-018 Top FSM states: IDLE, RST_LOW, RST_SAMPLE, RST_REC, WR_BYTE, CONV_WAIT, RD_BYTE, CRC_CHK, FINISH.
REQ-019 Reset sequence:
- RST_LOW drives low for 480 us.
- RST_SAMPLE releases the line for 70 us and counts the low time of dq_in.
- RST_REC waits a further 410 us.
REQ-020 If the low count in RST_SAMPLE is below PRESENCE_MIN_US, the FSM sets err_presence and goes directly to FINISH.
REQ-021 Phase A command sequence: reset, 0xCC, 0x44, then CONV_WAIT for CONV_WAIT_MS with the line released.
REQ-022 Phase B command sequence: reset, 0xCC, 0xBE, then RD_BYTE repeated READ_BYTES times.
REQ-023 Bytes are transferred LSB first.
REQ-024 Write-0 slot: 60 us low, then 10 us released.
REQ-025 Write-1 slot: 6 us low, then 64 us released.
REQ-026 Read slot: 6 us low, release, sample dq_in at 15 us from slot start, 70 us total.
REQ-027 CRC-8 (Dallas, x^8+x^5+x^4+1, init 0x00) is computed serially over all read bits.
- If READ_BYTES=9, a remainder other than 0 sets err_crc.
- If READ_BYTES<9, the CRC check is skipped.
REQ-028 On pass, the block updates temp_data and sets temp_valid in the FINISH cycle.
REQ-029 On any error, temp_data and temp_valid keep their previous values.
REQ-030 FINISH pulses done for exactly 1 cycle, clears busy, and returns to IDLE.
REQ-031 start while busy=1 is ignored; start coinciding with done is also ignored.
REQ-032 An accepted start clears err_presence and err_crc.

Reset
REQ-033 While rst_n=0, all of the following hold immediately, without waiting for a clock edge:
- dq_oe=0, dq_out=0, busy=0, done=0, err_presence=0, err_crc=0.
- temp_data=16'h0000, temp_valid=0.
- FSM=IDLE; tick, bit and byte counters are 0.
REQ-034 Reset asserted mid-slot releases the line in the same cycle; the partial transfer is discarded.

Structure
REQ-035 Package onewire_pkg holds:
- the state enum;
- the command constants CMD_SKIP_ROM=8'hCC, CMD_CONVERT=8'h44, CMD_READ_SP=8'hBE;
- the slot and reset timing constants in us.
REQ-036 Sub-module onewire_slot is the bit/reset timing engine.
- Inputs: req, kind (reset/write0/write1/read).
- Outputs: ack, rx_bit, presence.
- It owns the tick divider, dq_oe and the dq_in synchroniser.

Verification (FCLK_MHZ=10, CONV_WAIT_MS=1)
REQ-037 dq_in held at 1 and start pulsed -> the bench shall see:
- err_presence=1;
- done about 960 us after start;
- no write slots on the line.
REQ-038 Slave model answers scratchpad 50 05 4B 46 7F FF 0C 10 1C -> the bench shall see:
- temp_data=16'h0550, temp_valid=1, err_crc=0.
REQ-039 Same model with the last byte changed to 0x1D -> the bench shall see:
- err_crc=1;
- temp_data still holds its previous value.
REQ-040 Line monitor on the first 0xCC write -> low widths shall be 60,60,6,6,60,60,6,6 us.
REQ-041 rst_n pulled low during RD_BYTE -> dq_oe=0 in the same cycle, busy=0; the next start then completes normally.
REQ-042 Second start while busy -> ignored; exactly one done pulse is seen.

Source files
------------

// File: rtl/onewire_pkg.sv
// Shared types, command bytes and 1-Wire timing (in microseconds) for the
// DS18B20-style temperature master.
package onewire_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_RST_LOW, ST_RST_SAMPLE, ST_RST_REC, ST_WR_BYTE,
    ST_CONV_WAIT, ST_RD_BYTE, ST_CRC_CHK, ST_FINISH
  } state_e;

  typedef enum logic [1:0] {
    SLOT_RESET, SLOT_WRITE0, SLOT_WRITE1, SLOT_READ
  } slot_kind_e;

  localparam logic [7:0] CMD_SKIP_ROM = 8'hCC;
  localparam logic [7:0] CMD_CONVERT  = 8'h44;
  localparam logic [7:0] CMD_READ_SP  = 8'hBE;

  localparam logic [8:0] T_RST_LOW_US    = 9'd480;
  localparam logic [8:0] T_RST_SAMPLE_US = 9'd70;
  localparam logic [8:0] T_RST_REC_US    = 9'd410;
  localparam logic [8:0] T_SLOT_US       = 9'd70;
  localparam logic [8:0] T_W0_LOW_US     = 9'd60;
  localparam logic [8:0] T_W1_LOW_US     = 9'd6;
  localparam logic [8:0] T_RD_LOW_US     = 9'd6;
  localparam logic [8:0] T_RD_SAMPLE_US  = 9'd15;

  // Dallas CRC-8 (x^8+x^5+x^4+1), bits consumed LSB first.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
    logic fb;
    fb = crc[0] ^ b;
    crc8_step = {1'b0, crc[7:1]} ^ (fb ? 8'h8C : 8'h00);
  endfunction

endpackage

// File: rtl/onewire_slot.sv
// Bit/reset timing engine: tick divider, line drive and dq_in synchroniser.
// A reset request runs low/sample/recovery back to back, acking each segment.
module onewire_slot import onewire_pkg::*; #(
  parameter int FCLK_MHZ        = 125,
  parameter int PRESENCE_MIN_US = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  slot_kind_e kind,
  input  logic       dq_in,
  output logic       ack,
  output logic       rx_bit,
  output logic       presence,
  output logic       tick,
  output logic       dq_oe
);

  localparam int DW = (FCLK_MHZ > 1) ? $clog2(FCLK_MHZ) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(FCLK_MHZ - 1);
  localparam logic [6:0]    PRES_MIN = 7'(PRESENCE_MIN_US);

  logic [DW-1:0] div_q, div_d;
  logic [1:0]    sync_q;
  logic          active_q, active_d;
  slot_kind_e    kind_q, kind_d;
  logic [1:0]    seg_q, seg_d;
  logic [8:0]    us_q, us_d;
  logic [6:0]    low_q, low_d;
  logic          ack_q, ack_d, rx_q, rx_d, pres_q, pres_d;
  logic          accept, is_rst;
  logic [8:0]    seg_len, low_len;

  assign tick     = (div_q == DIV_LAST);
  assign is_rst   = (kind_q == SLOT_RESET);
  // Hold off one cycle after ack so the requester can present the next kind.
  assign accept   = req && !active_q && !ack_q;
  assign ack      = ack_q;
  assign rx_bit   = rx_q;
  assign presence = pres_q;
  assign dq_oe    = active_q && (is_rst ? (seg_q == 2'd0) : (us_q < low_len));

  always_comb begin
    div_d = (accept || tick) ? '0 : div_q + 1'b1;

    seg_len = T_SLOT_US;
    if (is_rst) begin
      case (seg_q)
        2'd0:    seg_len = T_RST_LOW_US;
        2'd1:    seg_len = T_RST_SAMPLE_US;
        default: seg_len = T_RST_REC_US;
      endcase
    end
    case (kind_q)
      SLOT_WRITE0: low_len = T_W0_LOW_US;
      SLOT_WRITE1: low_len = T_W1_LOW_US;
      default:     low_len = T_RD_LOW_US;
    endcase

    active_d = active_q;
    kind_d   = kind_q;
    seg_d    = seg_q;
    us_d     = us_q;
    low_d    = low_q;
    ack_d    = 1'b0;
    rx_d     = rx_q;
    pres_d   = pres_q;

    if (accept) begin
      active_d = 1'b1;
      kind_d   = kind;
      seg_d    = 2'd0;
      us_d     = '0;
      low_d    = '0;
    end else if (active_q && tick) begin
      if (is_rst && seg_q == 2'd1 && !sync_q[1]) low_d = low_q + 7'd1;
      if (kind_q == SLOT_READ && us_q == T_RD_SAMPLE_US - 9'd1) rx_d = sync_q[1];
      if (us_q == seg_len - 9'd1) begin
        us_d  = '0;
        ack_d = 1'b1;
        if (is_rst && seg_q != 2'd2) begin
          seg_d = seg_q + 2'd1;
          if (seg_q == 2'd1) pres_d = (low_d >= PRES_MIN);
        end else begin
          active_d = 1'b0;
        end
      end else begin
        us_d = us_q + 9'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= '0;
      sync_q   <= 2'b11;
      active_q <= 1'b0;
      kind_q   <= SLOT_RESET;
      seg_q    <= '0;
      us_q     <= '0;
      low_q    <= '0;
      ack_q    <= 1'b0;
      rx_q     <= 1'b0;
      pres_q   <= 1'b0;
    end else begin
      div_q    <= div_d;
      sync_q   <= {sync_q[0], dq_in};
      active_q <= active_d;
      kind_q   <= kind_d;
      seg_q    <= seg_d;
      us_q     <= us_d;
      low_q    <= low_d;
      ack_q    <= ack_d;
      rx_q     <= rx_d;
      pres_q   <= pres_d;
    end
  end

endmodule

// File: rtl/onewire_temp_master.sv
// 1-Wire temperature master: Convert T, wait, read scratchpad, CRC check,
// publish {byte1, byte0} as the raw temperature.
module onewire_temp_master import onewire_pkg::*; #(
  parameter int FCLK_MHZ        = 125,
  parameter int CONV_WAIT_MS    = 750,
  parameter int READ_BYTES      = 9,
  parameter int PRESENCE_MIN_US = 60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err_presence,
  output logic        err_crc,
  output logic [15:0] temp_data,
  output logic        temp_valid,
  output logic        dq_oe,
  output logic        dq_out,
  input  logic        dq_in
);

  localparam int CONV_US = CONV_WAIT_MS * 1000;
  localparam int CW      = $clog2(CONV_US + 1);
  localparam logic [CW-1:0] CONV_LAST = CW'(CONV_US - 1);
  localparam logic [3:0]    RB_LAST   = 4'(READ_BYTES - 1);

  state_e      state_q, state_d;
  logic        phase_q, phase_d;     // 0: convert pass, 1: read pass
  logic        wr_idx_q, wr_idx_d;   // 0: skip-ROM byte, 1: function byte
  logic [2:0]  bit_q, bit_d;
  logic [3:0]  byte_q, byte_d;
  logic [CW-1:0] conv_q, conv_d;
  logic [7:0]  crc_q, crc_d;
  logic [15:0] sr_q, sr_d;
  logic        errp_q, errp_d, errc_q, errc_d;
  logic [15:0] temp_q, temp_d;
  logic        tval_q, tval_d;

  logic        slot_req, slot_ack, slot_rx, slot_pres, slot_tick;
  slot_kind_e  slot_kind;
  logic [7:0]  cur_byte;

  onewire_slot #(.FCLK_MHZ(FCLK_MHZ), .PRESENCE_MIN_US(PRESENCE_MIN_US)) u_slot (
    .clk(clk), .rst_n(rst_n), .req(slot_req), .kind(slot_kind), .dq_in(dq_in),
    .ack(slot_ack), .rx_bit(slot_rx), .presence(slot_pres), .tick(slot_tick),
    .dq_oe(dq_oe)
  );

  assign dq_out       = 1'b0;
  assign busy         = (state_q != ST_IDLE) && (state_q != ST_FINISH);
  assign done         = (state_q == ST_FINISH);
  assign err_presence = errp_q;
  assign err_crc      = errc_q;
  assign temp_data    = temp_q;
  assign temp_valid   = tval_q;
  assign cur_byte     = !wr_idx_q ? CMD_SKIP_ROM : (phase_q ? CMD_READ_SP : CMD_CONVERT);

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    wr_idx_d  = wr_idx_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    conv_d    = conv_q;
    crc_d     = crc_q;
    sr_d      = sr_q;
    errp_d    = errp_q;
    errc_d    = errc_q;
    temp_d    = temp_q;
    tval_d    = tval_q;
    slot_req  = 1'b0;
    slot_kind = SLOT_RESET;

    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_RST_LOW;
        phase_d = 1'b0;
        errp_d  = 1'b0;
        errc_d  = 1'b0;
      end
      ST_RST_LOW: begin
        slot_req = 1'b1;
        if (slot_ack) state_d = ST_RST_SAMPLE;
      end
      ST_RST_SAMPLE: if (slot_ack) begin
        errp_d  = !slot_pres;
        state_d = ST_RST_REC;
      end
      ST_RST_REC: if (slot_ack) begin
        state_d  = errp_q ? ST_FINISH : ST_WR_BYTE;
        wr_idx_d = 1'b0;
        bit_d    = '0;
      end
      ST_WR_BYTE: begin
        slot_req  = 1'b1;
        slot_kind = cur_byte[bit_q] ? SLOT_WRITE1 : SLOT_WRITE0;
        if (slot_ack) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            if (!wr_idx_q) begin
              wr_idx_d = 1'b1;
            end else if (phase_q) begin
              state_d = ST_RD_BYTE;
              byte_d  = '0;
              crc_d   = '0;
            end else begin
              state_d = ST_CONV_WAIT;
              conv_d  = '0;
            end
          end
        end
      end
      ST_CONV_WAIT: if (slot_tick) begin
        if (conv_q == CONV_LAST) begin
          state_d = ST_RST_LOW;
          phase_d = 1'b1;
        end else begin
          conv_d = conv_q + 1'b1;
        end
      end
      ST_RD_BYTE: begin
        slot_req  = 1'b1;
        slot_kind = SLOT_READ;
        if (slot_ack) begin
          crc_d = crc8_step(crc_q, slot_rx);
          // First 16 bits LSB-first leave {byte1, byte0} in the shifter.
          if (byte_q < 4'd2) sr_d = {slot_rx, sr_q[15:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            byte_d = byte_q + 4'd1;
            if (byte_q == RB_LAST) state_d = ST_CRC_CHK;
          end
        end
      end
      ST_CRC_CHK: begin
        if (READ_BYTES == 9 && crc_q != 8'h00) errc_d = 1'b1;
        state_d = ST_FINISH;
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        if (!errp_q && !errc_q) begin
          temp_d = sr_q;
          tval_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      phase_q  <= 1'b0;
      wr_idx_q <= 1'b0;
      bit_q    <= '0;
      byte_q   <= '0;
      conv_q   <= '0;
      crc_q    <= '0;
      sr_q     <= '0;
      errp_q   <= 1'b0;
      errc_q   <= 1'b0;
      temp_q   <= '0;
      tval_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      wr_idx_q <= wr_idx_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      conv_q   <= conv_d;
      crc_q    <= crc_d;
      sr_q     <= sr_d;
      errp_q   <= errp_d;
      errc_q   <= errc_d;
      temp_q   <= temp_d;
      tval_q   <= tval_d;
    end
  end

endmodule

// File: tb/tb_onewire_temp_master.sv
// Directed bench: behavioural DS18B20-like slave on the line plus a slot-width
// monitor; expected values are hand-derived constants.
`timescale 1ns/1ps
module tb_onewire_temp_master;

  localparam int FCLK = 10;
  localparam logic [71:0] SP_GOOD = {8'h1C, 8'h10, 8'h0C, 8'hFF, 8'h7F, 8'h46, 8'h4B, 8'h05, 8'h50};
  localparam logic [71:0] SP_BAD  = {8'h1D, 8'h10, 8'h0C, 8'hFF, 8'h7F, 8'h46, 8'h4B, 8'h05, 8'h50};

  logic        clk = 1'b0;
  logic        rst_n, start, dq_in;
  logic        busy, done, err_presence, err_crc, temp_valid, dq_oe, dq_out;
  logic [15:0] temp_data;

  int ncmp = 0;
  int nerr = 0;

  logic        force_hi, mclr, oe_prev;
  logic [71:0] sp;
  logic [15:0] wbits;
  int          lowc, pull, slot_idx, nslots, done_cnt;
  int          widths [8];
  int          exp_w  [8] = '{60, 60, 6, 6, 60, 60, 6, 6};

  always #50 clk = ~clk;

  onewire_temp_master #(
    .FCLK_MHZ(FCLK), .CONV_WAIT_MS(1), .READ_BYTES(9), .PRESENCE_MIN_US(60)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .err_presence(err_presence), .err_crc(err_crc), .temp_data(temp_data),
    .temp_valid(temp_valid), .dq_oe(dq_oe), .dq_out(dq_out), .dq_in(dq_in)
  );

  // Open-drain line: low when the master drives or the slave pulls.
  assign dq_in = force_hi | ~(dq_oe | (pull != 0));

  always @(posedge clk) begin
    if (mclr) begin
      oe_prev  <= 1'b0;
      lowc     <= 0;
      pull     <= 0;
      slot_idx <= 0;
      nslots   <= 0;
      wbits    <= '0;
      done_cnt <= 0;
    end else begin
      oe_prev <= dq_oe;
      if (done) done_cnt <= done_cnt + 1;
      if (dq_oe) begin
        lowc <= lowc + 1;
        if (!oe_prev && wbits[15:8] == 8'hBE && slot_idx >= 16 && slot_idx < 88 && !sp[slot_idx-16])
          pull <= 300;
        else if (pull != 0)
          pull <= pull - 1;
      end else begin
        lowc <= 0;
        if (pull != 0) pull <= pull - 1;
        if (oe_prev) begin
          if (lowc >= 4000) begin
            slot_idx <= 0;
            wbits    <= '0;
            pull     <= 1200;
          end else begin
            nslots   <= nslots + 1;
            slot_idx <= slot_idx + 1;
            if (slot_idx < 16) wbits[slot_idx] <= (lowc < 150);
            if (slot_idx < 8) widths[slot_idx] <= lowc;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lim, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < lim) begin
      @(negedge clk);
      cyc++;
    end
    chk(tag, done, 1'b1);
  endtask

  task automatic clear_model();
    mclr = 1'b1;
    @(negedge clk);
    mclr = 1'b0;
  endtask

  initial begin
    int cyc;
    rst_n = 1'b1; start = 1'b0; force_hi = 1'b0; mclr = 1'b1; sp = SP_GOOD;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dq_oe", dq_oe, 0);
    chk("rst_dq_out", dq_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err_presence", err_presence, 0);
    chk("rst_err_crc", err_crc, 0);
    chk("rst_temp_data", temp_data, 16'h0000);
    chk("rst_temp_valid", temp_valid, 0);
    rst_n = 1'b1;

    // No slave: line stays high, presence fails after the full reset sequence.
    force_hi = 1'b1;
    clear_model();
    pulse_start();
    chk("t1_busy", busy, 1);
    wait_done("t1_done", 12000, cyc);
    chk("t1_latency_960us", (cyc >= 9580 && cyc <= 9620), 1);
    chk("t1_err_presence", err_presence, 1);
    chk("t1_err_crc", err_crc, 0);
    chk("t1_temp_valid", temp_valid, 0);
    chk("t1_no_write_slots", nslots, 0);
    repeat (3) @(negedge clk);
    chk("t1_done_pulses", done_cnt, 1);
    chk("t1_busy_after", busy, 0);

    // Good scratchpad, plus a start while busy and a start coinciding with done.
    force_hi = 1'b0;
    sp = SP_GOOD;
    clear_model();
    pulse_start();
    repeat (5) @(negedge clk);
    chk("t2_err_presence_cleared", err_presence, 0);
    repeat (100) @(negedge clk);
    pulse_start();
    wait_done("t2_done", 110000, cyc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("t2_busy_after", busy, 0);
    chk("t2_done_pulses", done_cnt, 1);
    chk("t2_err_presence", err_presence, 0);
    chk("t2_err_crc", err_crc, 0);
    chk("t2_temp_data", temp_data, 16'h0550);
    chk("t2_temp_valid", temp_valid, 1);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t2_cc_width%0d", i), (widths[i] + FCLK / 2) / FCLK, exp_w[i]);

    // Reset asserted mid read slot.
    clear_model();
    pulse_start();
    cyc = 0;
    while (!(slot_idx == 30 && dq_oe === 1'b1) && cyc < 110000) begin
      @(negedge clk);
      cyc++;
    end
    chk("t3_in_read_slot", dq_oe, 1);
    #13 rst_n = 1'b0;
    #1;
    chk("t3_rst_dq_oe", dq_oe, 0);
    chk("t3_rst_busy", busy, 0);
    chk("t3_rst_temp_valid", temp_valid, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Next start after the abort completes normally.
    clear_model();
    pulse_start();
    wait_done("t4_done", 110000, cyc);
    repeat (2) @(negedge clk);
    chk("t4_err_presence", err_presence, 0);
    chk("t4_err_crc", err_crc, 0);
    chk("t4_temp_data", temp_data, 16'h0550);
    chk("t4_temp_valid", temp_valid, 1);

    // Corrupted CRC byte: error flagged, previous temperature kept.
    sp = SP_BAD;
    clear_model();
    pulse_start();
    wait_done("t5_done", 110000, cyc);
    repeat (2) @(negedge clk);
    chk("t5_err_crc", err_crc, 1);
    chk("t5_err_presence", err_presence, 0);
    chk("t5_temp_data_kept", temp_data, 16'h0550);
    chk("t5_temp_valid_kept", temp_valid, 1);
    chk("t5_done_pulses", done_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
